zx_video_stage: RTL and testbench

Parametrised pixel output stage between the ZX80/ZX81 core's video signals and the board's VGA/DVI colour pins. Replaces the fixed 1-bit-to-white mapping with a run-time-writable palette, optional inverse video and scanline dimming. Sync and blank are delay-matched through the same pipeline. Runs in the system clock domain, qualified by a pixel clock enable.

---
 rtl/zx_video_pkg.sv | 20 ++
 rtl/zx_palette.sv | 34 +++
 rtl/zx_video_stage.sv | 153 +++++++++++++++
 tb/tb_zx_video_stage.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/zx_video_pkg.sv
// Shared constants for the ZX video output stage: parameter defaults,
// {R,G,B} channel positions and the grey ramp used as the palette reset image.
package zx_video_pkg;

  localparam int DEF_IN_BITS = 1;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_LATENCY = 2;

  // Channel k of a packed {R,G,B} word lives at bits [k*DEPTH +: DEPTH].
  localparam int CH_R = 2;
  localparam int CH_G = 1;
  localparam int CH_B = 0;

  function automatic int unsigned default_grey(input int unsigned idx,
                                               input int unsigned in_bits,
                                               input int unsigned depth);
    return (idx * ((32'd1 << depth) - 32'd1)) / ((32'd1 << in_bits) - 32'd1);
  endfunction

endpackage

// File: rtl/zx_palette.sv
// Register-file palette: synchronous write, combinational read, grey ramp on reset.
// Latency: write visible to reads after the writing edge; no backpressure.
module zx_palette
  import zx_video_pkg::*;
#(
  parameter int IN_BITS = DEF_IN_BITS,
  parameter int DEPTH   = DEF_DEPTH
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 we,
  input  logic [IN_BITS-1:0]   waddr,
  input  logic [3*DEPTH-1:0]   wdata,
  input  logic [IN_BITS-1:0]   raddr,
  output logic [3*DEPTH-1:0]   rdata
);

  localparam int ENTRIES = 1 << IN_BITS;

  logic [3*DEPTH-1:0] mem [ENTRIES];

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem[i] <= {3{DEPTH'(default_grey(i, IN_BITS, DEPTH))}};
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/zx_video_stage.sv
// Palette/inverse/scanline pixel stage with delay-matched sync and blank.
// Latency LATENCY ce_pix pulses; no backpressure, everything holds while ce_pix=0.
module zx_video_stage
  import zx_video_pkg::*;
#(
  parameter int IN_BITS = DEF_IN_BITS,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 ce_pix,
  input  logic [IN_BITS-1:0]   video,
  input  logic                 hsync_in,
  input  logic                 vsync_in,
  input  logic                 blank_in,
  input  logic                 invert,
  input  logic                 scanlines,
  input  logic                 pal_we,
  input  logic [IN_BITS-1:0]   pal_addr,
  input  logic [3*DEPTH-1:0]   pal_data,
  output logic [DEPTH-1:0]     red,
  output logic [DEPTH-1:0]     green,
  output logic [DEPTH-1:0]     blue,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 blank
);

  typedef struct packed {
    logic [3*DEPTH-1:0] rgb;
    logic               odd;
    logic               scan;
    logic               hs;
    logic               vs;
    logic               bl;
  } stage_t;

  localparam stage_t STAGE_RST = '{rgb: '0, odd: 1'b0, scan: 1'b0, hs: 1'b0, vs: 1'b0, bl: 1'b1};

  logic [IN_BITS-1:0] idx;
  logic [3*DEPTH-1:0] pal_rdata;
  logic               hs_prev;
  logic               vs_prev;
  logic               odd_line;
  logic               odd_next;
  stage_t             s0;
  stage_t             last;
  logic [3*DEPTH-1:0] colour;

  assign idx = video ^ {IN_BITS{invert}};

  // The lookup is captured at the sampling edge, so a write on that same
  // edge only shows up for pixels sampled afterwards.
  zx_palette #(
    .IN_BITS (IN_BITS),
    .DEPTH   (DEPTH)
  ) u_palette (
    .clk_sys (clk_sys),
    .reset   (reset),
    .we      (pal_we),
    .waddr   (pal_addr),
    .wdata   (pal_data),
    .raddr   (idx),
    .rdata   (pal_rdata)
  );

  // vsync rise wins over an hsync rise seen in the same sample.
  always_comb begin
    odd_next = odd_line;
    if (vsync_in && !vs_prev) begin
      odd_next = 1'b0;
    end else if (hsync_in && !hs_prev) begin
      odd_next = ~odd_line;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hs_prev  <= 1'b0;
      vs_prev  <= 1'b0;
      odd_line <= 1'b0;
    end else if (ce_pix) begin
      hs_prev  <= hsync_in;
      vs_prev  <= vsync_in;
      odd_line <= odd_next;
    end
  end

  always_comb begin
    s0      = STAGE_RST;
    s0.rgb  = pal_rdata;
    s0.odd  = odd_next;
    s0.scan = scanlines;
    s0.hs   = hsync_in;
    s0.vs   = vsync_in;
    s0.bl   = blank_in;
  end

  generate
    if (LATENCY == 1) begin : g_direct
      assign last = s0;
    end else begin : g_pipe
      stage_t pipe [1:LATENCY-1];

      always_ff @(posedge clk_sys) begin
        if (reset) begin
          for (int k = 1; k < LATENCY; k++) begin
            pipe[k] <= STAGE_RST;
          end
        end else if (ce_pix) begin
          pipe[1] <= s0;
          for (int k = 2; k < LATENCY; k++) begin
            pipe[k] <= pipe[k-1];
          end
        end
      end

      assign last = pipe[LATENCY-1];
    end
  endgenerate

  always_comb begin
    colour = last.rgb;
    if (last.scan && last.odd) begin
      for (int ch = 0; ch < 3; ch++) begin
        colour[ch*DEPTH +: DEPTH] = last.rgb[ch*DEPTH +: DEPTH] >> 1;
      end
    end
    if (last.bl) begin
      colour = '0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
      hsync <= 1'b0;
      vsync <= 1'b0;
      blank <= 1'b1;
    end else if (ce_pix) begin
      red   <= colour[CH_R*DEPTH +: DEPTH];
      green <= colour[CH_G*DEPTH +: DEPTH];
      blue  <= colour[CH_B*DEPTH +: DEPTH];
      hsync <= last.hs;
      vsync <= last.vs;
      blank <= last.bl;
    end
  end

endmodule

// File: tb/tb_zx_video_stage.sv
// Bench for zx_video_stage (IN_BITS=1, DEPTH=4, LATENCY=2): directed tables,
// hand sequences and a randomized run scored against a queue-based model.
module tb_zx_video_stage;

  localparam int IN_BITS = 1;
  localparam int DEPTH   = 4;
  localparam int LAT     = 2;
  localparam int NENT    = 1 << IN_BITS;

  logic                clk_sys = 1'b0;
  logic                reset = 1'b1;
  logic                ce_pix = 1'b1;
  logic [IN_BITS-1:0]  video = '0;
  logic                hsync_in = 1'b0;
  logic                vsync_in = 1'b0;
  logic                blank_in = 1'b0;
  logic                invert = 1'b0;
  logic                scanlines = 1'b0;
  logic                pal_we = 1'b0;
  logic [IN_BITS-1:0]  pal_addr = '0;
  logic [3*DEPTH-1:0]  pal_data = '0;
  logic [DEPTH-1:0]    red, green, blue;
  logic                hsync, vsync, blank;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_sys = ~clk_sys;

  zx_video_stage #(.IN_BITS(IN_BITS), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix), .video(video),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
    .invert(invert), .scanlines(scanlines), .pal_we(pal_we),
    .pal_addr(pal_addr), .pal_data(pal_data), .red(red), .green(green),
    .blue(blue), .hsync(hsync), .vsync(vsync), .blank(blank)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: palette array, parity bit and a delay queue of finished pixels.
  typedef struct {
    bit                 valid;
    logic [3*DEPTH-1:0] rgb;
    logic               hs, vs, bl;
  } mout_t;

  logic [3*DEPTH-1:0] pal_m [NENT];
  bit                 odd_m, hs_p, vs_p;
  mout_t              q[$];
  mout_t              cur = '{0, '0, 0, 0, 1};

  always @(posedge clk_sys) begin
    logic [IN_BITS-1:0] ix;
    logic [3*DEPTH-1:0] c;
    if (reset) begin
      for (int i = 0; i < NENT; i++)
        pal_m[i] = {3{DEPTH'(i * ((1 << DEPTH) - 1) / ((1 << IN_BITS) - 1))}};
      odd_m = 0; hs_p = 0; vs_p = 0;
      q.delete();
      for (int i = 0; i < LAT - 1; i++) q.push_back('{0, '0, 0, 0, 1});
      cur = '{1, '0, 0, 0, 1};
    end else begin
      if (ce_pix) begin
        if (vsync_in && !vs_p) odd_m = 0;
        else if (hsync_in && !hs_p) odd_m = !odd_m;
        hs_p = hsync_in;
        vs_p = vsync_in;
        ix = video ^ {IN_BITS{invert}};
        c = pal_m[ix];
        if (scanlines && odd_m)
          for (int ch = 0; ch < 3; ch++) c[ch*DEPTH +: DEPTH] = c[ch*DEPTH +: DEPTH] / 2;
        if (blank_in) c = '0;
        q.push_back('{1, c, hsync_in, vsync_in, blank_in});
        cur = q.pop_front();
      end
      if (pal_we) pal_m[pal_addr] = pal_data;
    end
    #1;
    if (cur.valid)
      chk("scoreboard", {red, green, blue, hsync, vsync, blank},
          {cur.rgb, cur.hs, cur.vs, cur.bl});
  end

  typedef struct {
    logic v, inv, bl;
    logic [11:0] exp_rgb;
    logic exp_bl;
  } vec_t;

  typedef struct {
    logic hs, vs;
    logic [11:0] exp_rgb;
  } scan_t;

  vec_t  tbl[8];
  scan_t stbl[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 12'hFFF, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 12'hFFF, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 12'h000, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 12'h000, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 12'h000, 1'b1};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 12'hFFF, 1'b0};

    stbl[0] = '{1'b0, 1'b1, 12'hFFF};
    stbl[1] = '{1'b0, 1'b0, 12'hFFF};
    stbl[2] = '{1'b1, 1'b0, 12'h777};
    stbl[3] = '{1'b0, 1'b0, 12'h777};
    stbl[4] = '{1'b1, 1'b0, 12'hFFF};
    stbl[5] = '{1'b0, 1'b0, 12'hFFF};
    stbl[6] = '{1'b1, 1'b0, 12'h777};
    stbl[7] = '{1'b0, 1'b0, 12'h777};
    stbl[8] = '{1'b1, 1'b1, 12'hFFF};
    stbl[9] = '{1'b0, 1'b0, 12'hFFF};

    repeat (3) @(posedge clk_sys);
    #2;
    chk("reset_out", {red, green, blue, hsync, vsync, blank}, 15'h0001);
    @(negedge clk_sys);
    reset = 1'b0;

    // Output after edge n shows the sample taken at edge n-1.
    for (int n = 0; n <= 8; n++) begin
      @(negedge clk_sys);
      if (n < 8) begin
        video = tbl[n].v; invert = tbl[n].inv; blank_in = tbl[n].bl;
      end else begin
        video = 0; invert = 0; blank_in = 0;
      end
      @(posedge clk_sys); #2;
      if (n >= 1)
        chk($sformatf("tbl%0d", n - 1), {red, green, blue, blank},
            {tbl[n-1].exp_rgb, tbl[n-1].exp_bl});
    end

    // Palette write on the same edge as a lookup of that entry.
    @(negedge clk_sys);
    video = 1; pal_we = 1; pal_addr = 1; pal_data = 12'h0F0;
    @(negedge clk_sys);
    pal_we = 0; video = 1;
    @(posedge clk_sys); #2;
    chk("pal_same_cycle", {red, green, blue}, 12'hFFF);
    @(negedge clk_sys);
    video = 0;
    @(posedge clk_sys); #2;
    chk("pal_new_value", {red, green, blue}, 12'h0F0);
    @(negedge clk_sys);
    pal_we = 1; pal_addr = 1; pal_data = 12'hFFF;
    @(negedge clk_sys);
    pal_we = 0;

    // Scanline parity: hsync toggles, vsync clears and wins a tie.
    scanlines = 1; video = 1;
    for (int n = 0; n <= 10; n++) begin
      @(negedge clk_sys);
      if (n < 10) begin
        hsync_in = stbl[n].hs; vsync_in = stbl[n].vs;
      end else begin
        hsync_in = 0; vsync_in = 0;
      end
      @(posedge clk_sys); #2;
      if (n >= 1)
        chk($sformatf("scan%0d", n - 1), {red, green, blue, hsync, vsync},
            {stbl[n-1].exp_rgb, stbl[n-1].hs, stbl[n-1].vs});
    end
    scanlines = 0;

    // Pixel enable every 8th cycle; the scoreboard covers hold and latency.
    for (int c = 0; c < 160; c++) begin
      @(negedge clk_sys);
      ce_pix = (c % 8 == 0);
      video = IN_BITS'($urandom_range(0, NENT - 1));
      hsync_in = ($urandom_range(0, 3) == 0);
      blank_in = ($urandom_range(0, 5) == 0);
    end
    @(negedge clk_sys);
    ce_pix = 1; hsync_in = 0; blank_in = 0;

    // Reset during active white pixels after a palette change.
    pal_we = 1; pal_addr = 1; pal_data = 12'h123; video = 1;
    @(negedge clk_sys);
    pal_we = 0;
    repeat (3) @(negedge clk_sys);
    reset = 1;
    @(posedge clk_sys); #2;
    chk("rst_mid_out", {red, green, blue, hsync, vsync, blank}, 15'h0001);
    @(negedge clk_sys);
    reset = 0;
    @(posedge clk_sys);
    @(posedge clk_sys); #2;
    chk("rst_pal_revert", {red, green, blue, blank}, {12'hFFF, 1'b0});

    // Randomized run against the model.
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk_sys);
      reset     = ($urandom_range(0, 299) == 0);
      ce_pix    = ($urandom_range(0, 3) != 0);
      video     = IN_BITS'($urandom_range(0, NENT - 1));
      hsync_in  = ($urandom_range(0, 4) == 0);
      vsync_in  = ($urandom_range(0, 29) == 0);
      blank_in  = ($urandom_range(0, 7) == 0);
      invert    = ($urandom_range(0, 5) == 0);
      scanlines = ($urandom_range(0, 1) == 0);
      pal_we    = ($urandom_range(0, 9) == 0);
      pal_addr  = IN_BITS'($urandom_range(0, NENT - 1));
      pal_data  = 12'($urandom_range(0, 4095));
    end
    @(negedge clk_sys);
    reset = 0; pal_we = 0;
    repeat (4) @(posedge clk_sys);
    #3;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
